// File: rtl/lu_share_arb_if.sv
// lu_share_arb_if
//   Groups the two request channels, the response channel and the completion
//   counter of the shared logic unit arbiter.
//   master : requesters + response consumer (drive valid/op/a/b and rsp_ready)
//   slave  : the arbiter (drives reqN_ready, rsp_*, done_cnt)
interface lu_share_arb_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic [2:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_ready;

  logic             req1_valid;
  logic [2:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_ready;

  logic             rsp_valid;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_y;
  logic             rsp_err;
  logic             rsp_ready;

  logic [7:0]       done_cnt;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_y, rsp_err,
    input  done_cnt
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_y, rsp_err,
    output done_cnt
  );
endinterface

// File: rtl/lu_share_arb.sv
// lu_share_arb
//   Shares one WIDTH-bit bitwise logic unit between two requesters with
//   round-robin arbitration, a registered result held under a valid/ready
//   response handshake, and an 8-bit wrapping count of completed responses.
// Ports
//   clk_i      : clock, all state changes on the rising edge
//   reset_n_i  : asynchronous active-low reset
//   bus        : lu_share_arb_if slave side (request ports, response port,
//                done_cnt)
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | arbitrate; ready is combinational to the granted requester
// EXEC  | compute on latched op/operands, register the response
// RESP  | hold the response until rsp_ready, then count it and return
module lu_share_arb #(
  parameter int WIDTH = 32
) (
  input  logic         clk_i,
  input  logic         reset_n_i,
  lu_share_arb_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             id_q, id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_y_q, rsp_y_d;
  logic             rsp_err_q, rsp_err_d;
  logic [7:0]       done_cnt_q, done_cnt_d;

  logic             grant0, grant1;
  logic             ready0, ready1;
  logic [WIDTH-1:0] lu_y;
  logic             lu_err;

  // Round robin: on a tie the requester that did not win last time goes.
  // last_grant resets to 1 so requester 0 wins the first tie.
  always_comb begin
    grant0 = bus.req0_valid && (!bus.req1_valid || last_grant_q);
    grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
  end

  // Ready is gated by reset so both readies read 0 while reset is held,
  // even with requests pending.
  assign ready0 = reset_n_i && (state_q == ST_IDLE) && grant0;
  assign ready1 = reset_n_i && (state_q == ST_IDLE) && grant1;

  always_comb begin
    lu_y   = '0;
    lu_err = 1'b0;
    case (op_q)
      3'b000:  lu_y = a_q & b_q;
      3'b001:  lu_y = a_q | b_q;
      3'b010:  lu_y = a_q ^ b_q;
      3'b011:  lu_y = ~(a_q & b_q);
      3'b100:  lu_y = ~(a_q | b_q);
      3'b101:  lu_y = ~(a_q ^ b_q);
      3'b110:  lu_y = ~a_q;
      default: lu_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_y_d      = rsp_y_q;
    rsp_err_d    = rsp_err_q;
    done_cnt_d   = done_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (ready0) begin
          op_d         = bus.req0_op;
          a_d          = bus.req0_a;
          b_d          = bus.req0_b;
          id_d         = 1'b0;
          last_grant_d = 1'b0;
          state_d      = ST_EXEC;
        end else if (ready1) begin
          op_d         = bus.req1_op;
          a_d          = bus.req1_a;
          b_d          = bus.req1_b;
          id_d         = 1'b1;
          last_grant_d = 1'b1;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_y_d     = lu_y;
        rsp_err_d   = lu_err;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          done_cnt_d  = done_cnt_q + 8'd1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_y_q      <= '0;
      rsp_err_q    <= 1'b0;
      done_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_y_q      <= rsp_y_d;
      rsp_err_q    <= rsp_err_d;
      done_cnt_q   <= done_cnt_d;
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_y      = rsp_y_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.done_cnt   = done_cnt_q;

endmodule

// File: tb/tb_lu_share_arb.sv
module tb_lu_share_arb;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  lu_share_arb_if #(.WIDTH(32)) bus ();

  lu_share_arb #(.WIDTH(32)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .bus       (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int exp_done;
  int last_w;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of the logic unit, straight from the opcode table.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] y, output logic e);
    e = 1'b0;
    case (op)
      3'd0: y = a & b;
      3'd1: y = a | b;
      3'd2: y = a ^ b;
      3'd3: y = ~(a & b);
      3'd4: y = ~(a | b);
      3'd5: y = ~(a ^ b);
      3'd6: y = ~a;
      default: begin y = 32'h0; e = 1'b1; end
    endcase
  endtask

  task automatic chk_no_ready(input string tag);
    chk({tag, "_rdy0"}, 32'(bus.req0_ready), 32'd0);
    chk({tag, "_rdy1"}, 32'(bus.req1_ready), 32'd0);
  endtask

  // Idle cycle: no requests, rsp_ready randomly high (must be ignored).
  task automatic idle_cycle();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'($urandom_range(0, 1));
    #1;
    chk_no_ready("idle");
    @(posedge clk); @(negedge clk);
    chk("idle_vld",  32'(bus.rsp_valid), 32'd0);
    chk("idle_done", 32'(bus.done_cnt), 32'(exp_done));
  endtask

  // One full transaction; called and returns at a falling edge with the DUT idle.
  task automatic do_op(input logic v0, input logic [2:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic v1, input logic [2:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                       input int stall, output int winner);
    int w;
    logic [31:0] ey;
    logic ee;
    bus.req0_valid = v0; bus.req0_op = op0; bus.req0_a = a0; bus.req0_b = b0;
    bus.req1_valid = v1; bus.req1_op = op1; bus.req1_a = a1; bus.req1_b = b1;
    bus.rsp_ready  = 1'($urandom_range(0, 1));
    if (v0 && v1) w = (last_w == 0) ? 1 : 0;
    else if (v0)  w = 0;
    else          w = 1;
    #1;
    chk("grant_rdy0", 32'(bus.req0_ready), 32'(w == 0));
    chk("grant_rdy1", 32'(bus.req1_ready), 32'(w == 1));
    if (w == 0) model(op0, a0, b0, ey, ee);
    else        model(op1, a1, b1, ey, ee);
    last_w = w;
    winner = w;
    @(posedge clk); @(negedge clk);
    // Winner's inputs may change freely once accepted.
    if (w == 0) begin
      bus.req0_valid = 1'($urandom_range(0, 1));
      bus.req0_op = 3'($urandom); bus.req0_a = $urandom; bus.req0_b = $urandom;
    end else begin
      bus.req1_valid = 1'($urandom_range(0, 1));
      bus.req1_op = 3'($urandom); bus.req1_a = $urandom; bus.req1_b = $urandom;
    end
    bus.rsp_ready = 1'($urandom_range(0, 1));
    #1;
    chk_no_ready("exec");
    chk("exec_vld", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("rsp_vld",  32'(bus.rsp_valid), 32'd1);
    chk("rsp_id",   32'(bus.rsp_id), 32'(w));
    chk("rsp_y",    bus.rsp_y, ey);
    chk("rsp_err",  32'(bus.rsp_err), 32'(ee));
    chk("rsp_done", 32'(bus.done_cnt), 32'(exp_done));
    chk_no_ready("resp");
    for (int s = 0; s < stall; s++) begin
      bus.rsp_ready = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("stall_vld",  32'(bus.rsp_valid), 32'd1);
      chk("stall_y",    bus.rsp_y, ey);
      chk("stall_id",   32'(bus.rsp_id), 32'(w));
      chk("stall_done", 32'(bus.done_cnt), 32'(exp_done));
      chk_no_ready("stall");
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    exp_done = (exp_done + 1) % 256;
    chk("hs_vld",  32'(bus.rsp_valid), 32'd0);
    chk("hs_done", 32'(bus.done_cnt), 32'(exp_done));
    chk("hs_hold", bus.rsp_y, ey);
    bus.rsp_ready = 1'b0;
    if (w == 0) bus.req0_valid = 1'b0;
    else        bus.req1_valid = 1'b0;
  endtask

  initial begin
    int w;
    logic [31:0] ra, rb;
    logic [2:0]  rop;
    logic [31:0] fa, fb;
    int sel;

    reset_n = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_op = 3'd0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b1; bus.req1_op = 3'd0; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp_ready  = 1'b0;
    @(negedge clk);
    chk("rst_vld",  32'(bus.rsp_valid), 32'd0);
    chk("rst_y",    bus.rsp_y, 32'd0);
    chk("rst_err",  32'(bus.rsp_err), 32'd0);
    chk("rst_id",   32'(bus.rsp_id), 32'd0);
    chk("rst_done", 32'(bus.done_cnt), 32'd0);
    chk_no_ready("rst");
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    last_w = 1;
    exp_done = 0;

    // Single requester, AND.
    do_op(1'b1, 3'd0, 32'hFFFF0000, 32'h0F0F0F0F, 1'b0, 3'd0, 32'h0, 32'h0, 0, w);
    chk("t2_y",    bus.rsp_y, 32'h0F0F0000);
    chk("t2_done", 32'(bus.done_cnt), 32'd1);

    // Both requesting continuously: grants must alternate.
    fa = $urandom; fb = $urandom;
    for (int i = 0; i < 4; i++) begin
      do_op(1'b1, 3'd2, fa, fb, 1'b1, 3'd5, 32'hAAAAAAAA, 32'hAAAAAAAA, 0, w);
      if (w == 1) chk("t3_xnor", bus.rsp_y, 32'hFFFFFFFF);
    end

    // Consumer stalls for 5 cycles.
    do_op(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 3'd1, $urandom, $urandom, 5, w);

    // NOT and reserved opcode.
    do_op(1'b1, 3'd6, 32'h12345678, $urandom, 1'b0, 3'd0, 32'h0, 32'h0, 1, w);
    chk("t5_not", bus.rsp_y, 32'hEDCBA987);
    do_op(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 3'd7, $urandom, $urandom, 0, w);
    chk("t5_rsv_y",   bus.rsp_y, 32'h0);
    chk("t5_rsv_err", 32'(bus.rsp_err), 32'd1);

    // Asynchronous reset while a response is pending.
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_op = 3'd1; bus.req1_a = 32'hFFFFFFFF; bus.req1_b = $urandom;
    bus.rsp_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    bus.req1_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("t1_pre_vld", 32'(bus.rsp_valid), 32'd1);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("t1_vld",  32'(bus.rsp_valid), 32'd0);
    chk("t1_y",    bus.rsp_y, 32'd0);
    chk("t1_id",   32'(bus.rsp_id), 32'd0);
    chk("t1_err",  32'(bus.rsp_err), 32'd0);
    chk("t1_done", 32'(bus.done_cnt), 32'd0);
    chk_no_ready("t1");
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    reset_n = 1'b1;
    last_w = 1;
    exp_done = 0;
    idle_cycle();

    // 256 randomized operations: counter must wrap back to 0.
    for (int i = 0; i < 256; i++) begin
      sel = $urandom_range(1, 3);
      rop = 3'($urandom); ra = $urandom; rb = $urandom;
      fa = $urandom; fb = $urandom;
      do_op(sel[0], rop, ra, rb, sel[1], 3'($urandom), fa, fb, $urandom_range(0, 3), w);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    chk("wrap_done", 32'(bus.done_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
